// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Imported by muldiv_seq.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV engine holding the HI/LO registers.
// Shift-add and restoring divide share one 2*WIDTH working register.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_n;
  logic               op_q, sa, sb;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               accept, dz;
  logic [WIDTH:0]     msum, rsh, diff;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   quo, rem;

  function automatic logic [WIDTH-1:0] absv(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign accept = (state == S_IDLE) && start;
  assign dz     = accept && (op == OP_DIV)
                  && (b == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (dz)          state_n = S_DONE;
        else if (accept) state_n = S_RUN;
      end
      S_RUN:  if (cnt == LAST) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // One shift-add or restoring-divide step, plus sign fix-up
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (acc[0] ? {1'b0, opnd} : '0);
    rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rsh - {1'b0, opnd};
    if (op_q == OP_MULT)
      step = {msum, acc[WIDTH-1:1]};
    else if (diff[WIDTH])
      step = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -acc[WIDTH-1:0]
                     : acc[WIDTH-1:0];
    rem  = sa ? -acc[2*WIDTH-1:WIDTH]
              : acc[2*WIDTH-1:WIDTH];
  end

  // Datapath, result registers and registered status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MULT;
      sa       <= 1'b0;
      sb       <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= (state_n == S_RUN)
                  || (state_n == S_FIX);
      done     <= (state_n == S_DONE);
      div_zero <= dz;
      unique case (state)
        S_IDLE: if (accept && !dz) begin
          op_q <= op;
          sa   <= a[WIDTH-1];
          sb   <= b[WIDTH-1];
          cnt  <= '0;
          if (op == OP_DIV) begin
            opnd <= absv(b);
            acc  <= {{WIDTH{1'b0}}, absv(a)};
          end else begin
            opnd <= absv(a);
            acc  <= {{WIDTH{1'b0}}, absv(b)};
          end
        end
        S_RUN: begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (op_q == OP_MULT) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq.
// Reference results come from plain 64-bit signed arithmetic.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;
  logic [31:0] mh, ml;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_op(
    input logic o, input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p = sx * sy;
      return p[63:0];
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_op(
    input logic o, input logic [31:0] x,
    input logic [31:0] y,
    output logic [31:0] rh, output logic [31:0] rl,
    output logic rdz, output int cyc,
    output int bcnt, output bit to
  );
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; bcnt = 0; to = 1'b1;
    rh = 'x; rl = 'x; rdz = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        to = 1'b0; rh = hi; rl = lo;
        rdz = div_zero;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else passes++;
    checks++;
    if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done);
    else passes++;
    checks++;
    if (div_zero !== 1'b0) $display("FAIL rst_dz got %b want 0", div_zero);
    else passes++;
    checks++;
    if (hi !== 32'h0) $display("FAIL rst_hi got %h want 0", hi);
    else passes++;
    checks++;
    if (lo !== 32'h0) $display("FAIL rst_lo got %h want 0", lo);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] rh, rl;
    logic rdz;
    int cyc, bc;
    bit to;
    do_op(1'b0, 32'd7, -32'sd3, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB)
      $display("FAIL mul7x-3 got %h_%h want ffffffff_ffffffeb", rh, rl);
    else passes++;
    checks++;
    if (cyc !== 34) $display("FAIL mul_latency got %0d want 34", cyc);
    else passes++;
    checks++;
    if (bc !== 33) $display("FAIL mul_busy got %0d want 33", bc);
    else passes++;
    do_op(1'b1, -32'sd7, 32'd2, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD)
      $display("FAIL div-7/2 got %h_%h want ffffffff_fffffffd", rh, rl);
    else passes++;
    do_op(1'b1, 32'd7, -32'sd2, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h1 || rl !== 32'hFFFFFFFD || rdz !== 1'b0)
      $display("FAIL div7/-2 got %h_%h dz %b want 00000001_fffffffd dz 0", rh, rl, rdz);
    else passes++;
  endtask

  task automatic test_div_zero;
    logic [31:0] rh, rl;
    logic rdz;
    int cyc, bc;
    bit to;
    do_op(1'b0, 32'd3, 32'd5, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h0 || rl !== 32'd15)
      $display("FAIL preload got %h_%h want 0_f", rh, rl);
    else passes++;
    do_op(1'b1, 32'd5, 32'd0, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || cyc !== 1 || rdz !== 1'b1)
      $display("FAIL dz_pulse got cyc %0d dz %b want 1 1", cyc, rdz);
    else passes++;
    checks++;
    if (bc !== 0) $display("FAIL dz_busy got %0d want 0", bc);
    else passes++;
    checks++;
    if (rh !== 32'h0 || rl !== 32'd15)
      $display("FAIL dz_keep got %h_%h want 0_f", rh, rl);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0)
      $display("FAIL dz_oneshot got %b%b want 00", done, div_zero);
    else passes++;
  endtask

  task automatic test_corners;
    logic [31:0] rh, rl;
    logic rdz;
    int cyc, bc;
    bit to;
    do_op(1'b0, 32'h80000000, 32'h80000000, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h40000000 || rl !== 32'h0)
      $display("FAIL mul_min got %h_%h want 40000000_0", rh, rl);
    else passes++;
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h0 || rl !== 32'h80000000)
      $display("FAIL div_ovf got %h_%h want 0_80000000", rh, rl);
    else passes++;
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h0 || rl !== 32'h1)
      $display("FAIL mul_m1 got %h_%h want 0_1", rh, rl);
    else passes++;
  endtask

  task automatic test_ignore_start;
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin seen = 1'b1; break; end
      if (cyc == 5 || cyc == 33) begin
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    checks++;
    if (!seen || cyc !== 34 || div_zero !== 1'b0)
      $display("FAIL ign_timing got cyc %0d dz %b want 34 0", cyc, div_zero);
    else passes++;
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6)
      $display("FAIL ign_result got %h_%h want 0_6", hi, lo);
    else passes++;
    start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ign_done got busy %b done %b want 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rh, rl;
    logic rdz;
    int cyc, bc;
    bit to;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = -32'sd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL mid_abort got busy %b %h_%h want 0 0_0", busy, hi, lo);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    do_op(1'b0, 32'd4, 32'd4, rh, rl, rdz, cyc, bc, to);
    checks++;
    if (to || rh !== 32'h0 || rl !== 32'd16)
      $display("FAIL post_rst got %h_%h want 0_10", rh, rl);
    else passes++;
    mh = rh; ml = rl;
  endtask

  task automatic test_random;
    logic [31:0] rh, rl, x, y;
    logic rdz, o;
    logic [63:0] e;
    int cyc, bc;
    bit to;
    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'($signed(x) >>> 24);
      if ($urandom_range(0, 3) == 0) y = 32'($signed(y) >>> 26);
      if ($urandom_range(0, 6) == 0) y = 32'h0;
      do_op(o, x, y, rh, rl, rdz, cyc, bc, to);
      if (o == 1'b1 && y == 32'h0) begin
        checks++;
        if (to || rdz !== 1'b1 || cyc !== 1 || rh !== mh || rl !== ml)
          $display("FAIL rnd_dz %h/0 got %h_%h dz %b cyc %0d want %h_%h 1 1", x, rh, rl, rdz, cyc, mh, ml);
        else passes++;
      end else begin
        e = ref_op(o, x, y);
        checks++;
        if (to || rdz !== 1'b0 || cyc !== 34 || rh !== e[63:32] || rl !== e[31:0])
          $display("FAIL rnd op%b %h,%h got %h_%h dz %b cyc %0d want %h_%h", o, x, y, rh, rl, rdz, cyc, e[63:32], e[31:0]);
        else passes++;
        mh = e[63:32]; ml = e[31:0];
      end
    end
  endtask

  initial begin
    mh = '0; ml = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_corners();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle signed multiply/divide sequencer for the multicycle CPU. It holds the HI/LO result registers and performs MULT and DIV through an iterative shift-add / restoring-divide engine. The control unit starts it with a one-cycle pulse and stalls on `busy`. The block flags division by zero so the control unit can raise the exception path, including the EPC write.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits.
- `clk`  in  1: CPU clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse, accepted only in IDLE.
- `op`  in  1: 0 = MULT, 1 = DIV. Sampled with `start`.
- `a`  in  WIDTH: rs operand, signed. Latched on accept.
- `b`  in  WIDTH: rt operand, signed. Latched on accept.
- `busy`  out  1: high in RUN and FIX.
- `done`  out  1: one-cycle completion pulse.
- `div_zero`  out  1: high together with `done` when a DIV has `b == 0`.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with `start=1` and either MULT or DIV with `b != 0`:
  - latch `op`, `|a|`, `|b|`, `sign_a`, `sign_b`;
  - clear the iteration counter;
  - go to RUN.
- IDLE with `start=1`, DIV and `b == 0`: go straight to DONE with `div_zero` pending. `hi` and `lo` stay unchanged.
- RUN, MULT: one radix-2 shift-add step per cycle into a 2·WIDTH unsigned accumulator.
- RUN, DIV: one restoring step per cycle, giving a WIDTH-bit quotient and remainder.
- RUN → FIX after WIDTH steps, when the counter reaches WIDTH−1.
- FIX: apply signs and write `hi`/`lo`, then go to DONE.
  - MULT: product negated if `sign_a ^ sign_b`. `hi` gets the upper WIDTH bits, `lo` the lower WIDTH bits.
  - DIV: `lo` gets the quotient, negated if `sign_a ^ sign_b` (truncation toward zero). `hi` gets the remainder, negated if `sign_a` (remainder takes the dividend's sign).
- DONE: `done=1` for one cycle. `div_zero` reflects the pending flag. Always returns to IDLE.
- `start` outside IDLE is ignored. This includes DONE, so back-to-back ops are at least one IDLE cycle apart.
- Overflow cases follow modulo-2^WIDTH arithmetic with no flag:
  - `0x80000000 / -1` gives `lo=0x80000000`, `hi=0`.
  - `0x80000000 * 0x80000000` gives `hi=0x40000000`, `lo=0`.
- `hi` and `lo` hold their value until the next FIX. They are never changed by a division by zero.

## Timing
- Reset values (async assert, low): state IDLE, `busy=0`, `done=0`, `div_zero=0`, `hi=0`, `lo=0`, counter 0.
- Reset asserted mid-operation aborts immediately. No partial result reaches `hi`/`lo`.
- Normal op, with `start` accepted at clock edge E0:
  - RUN occupies edges E1..E(WIDTH);
  - FIX writes `hi`/`lo` at edge E(WIDTH+1);
  - `done=1` in the cycle following E(WIDTH+1); with WIDTH=32 that is 34 cycles from accept.
- Divide-by-zero, with `start` accepted at E0: `done=1` and `div_zero=1` in the cycle following E0.
- `hi`/`lo` are valid, and may be read by MFHI/MFLO, from the cycle `done` is high onward.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - the state encoding enum (IDLE, RUN, FIX, DONE);
  - the `op` constants `OP_MULT=1'b0` and `OP_DIV=1'b1`;
  - the counter width `$clog2(WIDTH)`.
- Single module; no sub-module. The shift-add and restoring-divide steps share the 2·WIDTH working register and the counter.

## Test plan
- MULT `a=7`, `b=-3` → at `done`: `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. `done` 34 cycles after accept, and `busy` high for exactly the 33 cycles before it.
- DIV `a=-7`, `b=2` → `lo=0xFFFFFFFD` (−3), `hi=0xFFFFFFFF` (−1). DIV `a=7`, `b=-2` → `lo=0xFFFFFFFD`, `hi=1`.
- Preload via MULT 3*5 (`hi=0`, `lo=15`), then DIV `a=5`, `b=0` → next cycle `done=1`, `div_zero=1`, `busy` never high, `hi=0`, `lo=15` unchanged.
- Corner operands:
  - MULT `0x80000000*0x80000000` → `hi=0x40000000`, `lo=0`;
  - DIV `0x80000000/0xFFFFFFFF` → `lo=0x80000000`, `hi=0`;
  - MULT `0xFFFFFFFF*0xFFFFFFFF` → `hi=0`, `lo=1`.
- Start MULT 2*3; pulse `start` with DIV 9/0 at cycles 5 and 33 → both ignored. Result `hi=0`, `lo=6`, `div_zero=0`.
- Assert `reset` at cycle 10 of a DIV → `busy=0`, `hi=lo=0` immediately. After release, MULT 4*4 → `lo=16`.
